// File: rtl/mips_pkg.sv
// Shared datapath types for the MIPS memory stage.
// Every block that passes a 32-bit data or address word uses word_t.
package mips_pkg;
  localparam int DATA_W = 32;
  typedef logic [DATA_W-1:0] word_t;
endpackage

// File: rtl/wb_mux.sv
// Write-back select: picks the loaded memory word or the ALU result.
module wb_mux
  import mips_pkg::*;
(
  input  word_t mem_word,
  input  word_t alu_word,
  input  logic  sel,
  output word_t wb_word
);

  assign wb_word = sel ? mem_word : alu_word;

endmodule

// File: rtl/data_memory.sv
// Word-indexed data memory with a registered write-back output.
// A read and a write to the same index in one cycle returns the old word.
module data_memory
  import mips_pkg::*;
#(
  parameter int DEPTH = 256,
  parameter int IDX_W = 8
) (
  input  logic  clk,
  input  logic  rst,
  input  word_t address,
  input  word_t write_data,
  input  logic  MemRead,
  input  logic  MemWrite,
  input  logic  MemtoReg,
  output word_t read_data
);

  word_t             mem [DEPTH];
  logic [IDX_W-1:0]  idx;
  word_t             wb_word;

  // Upper address bits are ignored, so 0x104 and 0x004 share a word.
  assign idx = address[IDX_W-1:0];

  wb_mux u_wb_mux (
    .mem_word (mem[idx]),
    .alu_word (address),
    .sel      (MemtoReg),
    .wb_word  (wb_word)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
      read_data <= '0;
    end else begin
      if (MemWrite) begin
        mem[idx] <= write_data;
      end
      if (MemRead) begin
        read_data <= wb_word;
      end
    end
  end

endmodule

// File: tb/tb_data_memory.sv
// Directed and randomized checks of data_memory against an array-based model.
module tb_data_memory;
  import mips_pkg::*;

  logic  clk;
  logic  rst;
  word_t address;
  word_t write_data;
  logic  MemRead;
  logic  MemWrite;
  logic  MemtoReg;
  word_t read_data;

  int checks   = 0;
  int failures = 0;

  word_t mem_m [256];
  word_t rd_m;

  data_memory dut (
    .clk        (clk),
    .rst        (rst),
    .address    (address),
    .write_data (write_data),
    .MemRead    (MemRead),
    .MemWrite   (MemWrite),
    .MemtoReg   (MemtoReg),
    .read_data  (read_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input word_t obs, input word_t exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock: drive inputs, update the model with the spec's rules, compare.
  task automatic cyc(input string tag, input logic r, input word_t a, input word_t wd,
                     input logic rd, input logic wr, input logic m2r);
    int i;
    rst        = r;
    address    = a;
    write_data = wd;
    MemRead    = rd;
    MemWrite   = wr;
    MemtoReg   = m2r;
    @(posedge clk);
    i = int'(a % 256);
    if (!r) begin
      foreach (mem_m[k]) mem_m[k] = 32'h0;
      rd_m = 32'h0;
    end else begin
      if (rd) rd_m = m2r ? mem_m[i] : a;
      if (wr) mem_m[i] = wd;
    end
    #1;
    check(tag, read_data, rd_m);
  endtask

  initial begin
    word_t a;
    rst = 1'b1; address = '0; write_data = '0;
    MemRead = 1'b0; MemWrite = 1'b0; MemtoReg = 1'b0;
    rd_m = '0;
    @(negedge clk);

    cyc("reset", 0, 32'h8, 32'h1, 1, 1, 1);
    check("reset_const", read_data, 32'h0);

    cyc("wr4", 1, 32'h4, 32'hDEADBEEF, 0, 1, 0);
    cyc("ld4", 1, 32'h4, 32'h0, 1, 0, 1);
    check("ld4_const", read_data, 32'hDEADBEEF);
    cyc("wb4", 1, 32'h4, 32'h0, 1, 0, 0);
    check("wb4_const", read_data, 32'h4);
    cyc("wr8", 1, 32'h8, 32'hCAFEBABE, 0, 1, 0);
    cyc("ld8", 1, 32'h8, 32'h0, 1, 0, 1);
    check("ld8_const", read_data, 32'hCAFEBABE);
    cyc("wb8", 1, 32'h8, 32'h0, 1, 0, 0);
    check("wb8_const", read_data, 32'h8);

    cyc("reset2", 0, 32'h8, 32'h77, 1, 1, 1);
    check("reset2_const", read_data, 32'h0);
    cyc("ld4_clr", 1, 32'h4, 32'h0, 1, 0, 1);
    check("ld4_clr_const", read_data, 32'h0);
    cyc("ld8_clr", 1, 32'h8, 32'h0, 1, 0, 1);
    check("ld8_clr_const", read_data, 32'h0);

    cyc("wrA", 1, 32'hA, 32'h0DE07A01, 0, 1, 0);
    cyc("ldA", 1, 32'hA, 32'h0, 1, 0, 1);
    check("ldA_const", read_data, 32'h0DE07A01);
    cyc("wbA", 1, 32'hA, 32'h0, 1, 0, 0);
    check("wbA_const", read_data, 32'hA);
    cyc("ld8_after_A", 1, 32'h8, 32'h0, 1, 0, 1);
    check("ld8_after_A_const", read_data, 32'h0);

    cyc("ldA2", 1, 32'hA, 32'h0, 1, 0, 1);
    cyc("hold1", 1, 32'h33, 32'h0, 0, 0, 0);
    check("hold1_const", read_data, 32'h0DE07A01);
    cyc("hold2", 1, 32'h44, 32'h0, 0, 0, 1);
    check("hold2_const", read_data, 32'h0DE07A01);
    cyc("hold3", 1, 32'h55, 32'h0, 0, 0, 0);
    check("hold3_const", read_data, 32'h0DE07A01);

    cyc("wr20", 1, 32'h20, 32'h22222222, 0, 1, 0);
    cyc("collide", 1, 32'h20, 32'h11111111, 1, 1, 1);
    check("collide_old", read_data, 32'h22222222);
    cyc("after_collide", 1, 32'h20, 32'h0, 1, 0, 1);
    check("collide_new", read_data, 32'h11111111);

    cyc("wr104", 1, 32'h104, 32'h55AA55AA, 0, 1, 0);
    cyc("ld004", 1, 32'h4, 32'h0, 1, 0, 1);
    check("alias_const", read_data, 32'h55AA55AA);

    // Random traffic over a small index pool with varying upper bits.
    for (int n = 0; n < 600; n++) begin
      a = {$urandom_range(0, 3) == 0 ? $urandom() : 32'h0} & 32'hFFFF_FF00;
      a = a | 32'($urandom_range(0, 15));
      cyc("rand", ($urandom_range(0, 99) != 0), a, $urandom(),
          $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
          $urandom_range(0, 1) == 1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
